// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with 3-sample majority vote,
// parity/framing/overrun detection and an FWFT output FIFO.
// Ports: clk, rst (async, active-high), i_data (serial line, idle high)
//   o_data/o_parity_err/o_frame_err/o_valid with i_ready: head-of-FIFO handshake
//   o_overrun: 1-cycle pulse when a finished frame is dropped (FIFO full)
//   o_busy: receiver FSM not idle
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 32653061,
  parameter int BAUD_RATE  = 31250,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int LSB_FIRST  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_data,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int BIT_COUNT = CLK_FREQ / BAUD_RATE;
  localparam int SAMPLE    = BIT_COUNT / 2;
  localparam int CW        = $clog2(BIT_COUNT + 1);
  localparam int IW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int NW        = AW + 1;
  localparam int FW        = DATA_BITS + 2;

  localparam logic [CW-1:0] C_S0  = CW'(SAMPLE - 1);
  localparam logic [CW-1:0] C_S1  = CW'(SAMPLE);
  localparam logic [CW-1:0] C_S2  = CW'(SAMPLE + 1);
  localparam logic [CW-1:0] C_S3  = CW'(SAMPLE + 2);
  localparam logic [CW-1:0] C_END = CW'(BIT_COUNT - 1);
  localparam logic [IW-1:0] I_END = IW'(DATA_BITS - 1);
  localparam logic          S_END = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_BREAK = 3'd5
  } state_t;

  // Synchroniser
  logic s1_q;
  logic rx_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      s1_q   <= i_data;
      rx_s_q <= s1_q;
    end
  end

  // Receiver state
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  sidx_q, sidx_d;
  logic [1:0]            smp_q, smp_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  par_q, par_d;
  logic                  ferr_q, ferr_d;

  logic                  at_s0, at_s1, at_s2, at_s3, wrap;
  logic                  vote;
  logic                  last_stop;
  logic [IW-1:0]         bit_pos;

  assign at_s0 = (cnt_q == C_S0);
  assign at_s1 = (cnt_q == C_S1);
  assign at_s2 = (cnt_q == C_S2);
  assign at_s3 = (cnt_q == C_S3);
  assign wrap  = (cnt_q == C_END);

  // Third sample is taken live; the first two were latched earlier.
  assign vote = (smp_q[0] & smp_q[1]) |
                (smp_q[0] & rx_s_q) |
                (smp_q[1] & rx_s_q);

  assign last_stop = (sidx_q == S_END);
  assign bit_pos   = (LSB_FIRST != 0) ? idx_q : (I_END - idx_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sidx_q  <= 1'b0;
      smp_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sidx_q  <= sidx_d;
      smp_q   <= smp_d;
      data_q  <= data_d;
      par_q   <= par_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sidx_d  = sidx_q;
    smp_d   = smp_q;
    data_d  = data_q;
    par_d   = par_q;
    ferr_d  = ferr_q;

    if (state_q != ST_IDLE && state_q != ST_BREAK) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end
    if (at_s0) smp_d[0] = rx_s_q;
    if (at_s1) smp_d[1] = rx_s_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = ST_START;
          ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (at_s2 && vote) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (wrap) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (at_s2) begin
          for (int k = 0; k < DATA_BITS; k++) begin
            if (bit_pos == IW'(k)) data_d[k] = vote;
          end
        end
        if (wrap) begin
          if (idx_q == I_END) begin
            state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
            sidx_d  = 1'b0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_PAR: begin
        if (at_s2) par_d = vote;
        if (wrap) begin
          state_d = ST_STOP;
          sidx_d  = 1'b0;
        end
      end
      ST_STOP: begin
        if (at_s2 && !vote) ferr_d = 1'b1;
        // Frame ends one cycle after the last vote, not at bit end.
        if (at_s3 && last_stop) begin
          state_d = rx_s_q ? ST_IDLE : ST_BREAK;
          cnt_d   = '0;
        end else if (wrap) begin
          sidx_d = 1'b1;
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic
  logic          push;
  logic          perr;
  logic [FW-1:0] push_word;

  always_comb begin
    push   = (state_q == ST_STOP) && last_stop && at_s3;
    perr   = (PARITY != 0) &&
             ((^{data_q, par_q}) != (PARITY == 1));
    o_busy = (state_q != ST_IDLE);
  end

  assign push_word = {ferr_q, perr, data_q};

  // Output FIFO (first-word fall-through)
  logic [FW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [NW-1:0] fcnt_q, fcnt_d;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic [FW-1:0] head;

  assign full      = (fcnt_q == NW'(FIFO_DEPTH));
  assign o_valid   = (fcnt_q != '0);
  assign pop       = o_valid && i_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign wr_en     = push && (!full || pop);
  assign o_overrun = push && full && !pop;

  always_comb begin
    wr_d   = wr_en ? wr_q + AW'(1) : wr_q;
    rd_d   = pop ? rd_q + AW'(1) : rd_q;
    fcnt_d = fcnt_q;
    unique case ({wr_en, pop})
      2'b10:   fcnt_d = fcnt_q + NW'(1);
      2'b01:   fcnt_d = fcnt_q - NW'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fcnt_q <= fcnt_d;
      if (wr_en) mem_q[wr_q] <= push_word;
    end
  end

  assign head         = mem_q[rd_q];
  assign o_data       = head[DATA_BITS-1:0];
  assign o_parity_err = head[DATA_BITS];
  assign o_frame_err  = head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed bench for uart_rx_cfg, 10 clk per bit.
// Four receivers: 8N1 LSB/MSB first on line a, 8E1/8O1 on line b.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic rdy_n = 1'b1;
  logic rdy_m = 1'b1;
  logic rdy_e = 1'b1;
  logic rdy_o = 1'b1;

  logic [7:0] d_n, d_m, d_e, d_o;
  logic pe_n, pe_m, pe_e, pe_o;
  logic fe_n, fe_m, fe_e, fe_o;
  logic v_n, v_m, v_e, v_o;
  logic ov_n, ov_m, ov_e, ov_o;
  logic bz_n, bz_m, bz_e, bz_o;

  int errors = 0;
  int checks = 0;
  int ovc_n = 0;

  logic [9:0] q_n[$];
  logic [9:0] q_m[$];
  logic [9:0] q_e[$];
  logic [9:0] q_o[$];

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .LSB_FIRST(1), .FIFO_DEPTH(4)) u_n (
    .clk(clk), .rst(rst), .i_data(rx_a), .o_data(d_n),
    .o_parity_err(pe_n), .o_frame_err(fe_n), .o_valid(v_n),
    .i_ready(rdy_n), .o_overrun(ov_n), .o_busy(bz_n));

  uart_rx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .LSB_FIRST(0), .FIFO_DEPTH(4)) u_m (
    .clk(clk), .rst(rst), .i_data(rx_a), .o_data(d_m),
    .o_parity_err(pe_m), .o_frame_err(fe_m), .o_valid(v_m),
    .i_ready(rdy_m), .o_overrun(ov_m), .o_busy(bz_m));

  uart_rx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .LSB_FIRST(1), .FIFO_DEPTH(4)) u_e (
    .clk(clk), .rst(rst), .i_data(rx_b), .o_data(d_e),
    .o_parity_err(pe_e), .o_frame_err(fe_e), .o_valid(v_e),
    .i_ready(rdy_e), .o_overrun(ov_e), .o_busy(bz_e));

  uart_rx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
    .PARITY(1), .STOP_BITS(1), .LSB_FIRST(1), .FIFO_DEPTH(4)) u_o (
    .clk(clk), .rst(rst), .i_data(rx_b), .o_data(d_o),
    .o_parity_err(pe_o), .o_frame_err(fe_o), .o_valid(v_o),
    .i_ready(rdy_o), .o_overrun(ov_o), .o_busy(bz_o));

  // Record every accepted word, mid-cycle.
  always @(negedge clk) begin
    if (v_n && rdy_n) q_n.push_back({fe_n, pe_n, d_n});
    if (v_m && rdy_m) q_m.push_back({fe_m, pe_m, d_m});
    if (v_e && rdy_e) q_e.push_back({fe_e, pe_e, d_e});
    if (v_o && rdy_o) q_o.push_back({fe_o, pe_o, d_o});
    if (ov_n) ovc_n++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] fr8(input logic [7:0] d, input logic sb);
    return {6'b0, sb, d, 1'b0};
  endfunction

  function automatic logic [15:0] fr9(input logic [7:0] d, input logic p);
    return {5'b0, 1'b1, p, d, 1'b0};
  endfunction

  // gb: frame bit that gets a 1-clk inversion at offset 6 (-1 = none)
  task automatic send(input logic ln, input logic [15:0] bits,
                      input int n, input int gb);
    logic v;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 10; j++) begin
        v = bits[i] ^ ((i == gb) && (j == 6));
        if (ln) rx_b = v;
        else rx_a = v;
        tick();
      end
    end
  endtask

  task automatic clear_q();
    q_n.delete();
    q_m.delete();
    q_e.delete();
    q_o.delete();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({d_n, pe_n, fe_n, v_n, ov_n, bz_n} !== 14'h0) begin
      errors++;
      $display("FAIL reset_n: got %h want 0",
               {d_n, pe_n, fe_n, v_n, ov_n, bz_n});
    end
    checks++;
    if ({d_e, pe_e, fe_e, v_e, ov_e, bz_e} !== 14'h0) begin
      errors++;
      $display("FAIL reset_e: got %h want 0",
               {d_e, pe_e, fe_e, v_e, ov_e, bz_e});
    end
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_8n1();
    clear_q();
    send(1'b0, fr8(8'hA5, 1'b1), 10, -1);
    repeat (6) tick();
    checks++;
    if (q_n.size() !== 1) begin
      errors++;
      $display("FAIL a5_count: got %0d want 1", q_n.size());
    end
    checks++;
    if (q_n[0] !== 10'h0A5) begin
      errors++;
      $display("FAIL a5_lsb: got %h want 0a5", q_n[0]);
    end
    checks++;
    if (q_m[0] !== 10'h0A5) begin
      errors++;
      $display("FAIL a5_msb: got %h want 0a5", q_m[0]);
    end
    clear_q();
    send(1'b0, fr8(8'h01, 1'b1), 10, -1);
    repeat (6) tick();
    checks++;
    if (q_n[0] !== 10'h001 || q_n.size() !== 1) begin
      errors++;
      $display("FAIL 01_lsb: got %h want 001", q_n[0]);
    end
    checks++;
    if (q_m[0] !== 10'h080 || q_m.size() !== 1) begin
      errors++;
      $display("FAIL 01_msb: got %h want 080", q_m[0]);
    end
  endtask

  task automatic test_parity();
    clear_q();
    send(1'b1, fr9(8'h07, 1'b0), 11, -1);
    send(1'b1, fr9(8'h07, 1'b1), 11, -1);
    send(1'b1, fr9(8'h00, 1'b1), 11, -1);
    repeat (6) tick();
    checks++;
    if (q_e.size() !== 3 || q_o.size() !== 3) begin
      errors++;
      $display("FAIL par_count: got %0d/%0d want 3/3",
               q_e.size(), q_o.size());
    end
    checks++;
    if (q_e[0] !== 10'h107) begin
      errors++;
      $display("FAIL even_07_p0: got %h want 107", q_e[0]);
    end
    checks++;
    if (q_e[1] !== 10'h007) begin
      errors++;
      $display("FAIL even_07_p1: got %h want 007", q_e[1]);
    end
    checks++;
    if (q_e[2] !== 10'h100) begin
      errors++;
      $display("FAIL even_00_p1: got %h want 100", q_e[2]);
    end
    checks++;
    if (q_o[0] !== 10'h007) begin
      errors++;
      $display("FAIL odd_07_p0: got %h want 007", q_o[0]);
    end
    checks++;
    if (q_o[1] !== 10'h107) begin
      errors++;
      $display("FAIL odd_07_p1: got %h want 107", q_o[1]);
    end
    checks++;
    if (q_o[2] !== 10'h000) begin
      errors++;
      $display("FAIL odd_00_p1: got %h want 000", q_o[2]);
    end
  endtask

  task automatic test_glitch();
    clear_q();
    rx_a = 1'b0;
    repeat (3) tick();
    rx_a = 1'b1;
    checks++;
    if (bz_n !== 1'b1) begin
      errors++;
      $display("FAIL glitch_seen: got busy=%b want 1", bz_n);
    end
    for (int i = 0; i < 10; i++) begin
      if (bz_n === 1'b0) break;
      tick();
    end
    checks++;
    if (bz_n !== 1'b0) begin
      errors++;
      $display("FAIL glitch_idle: got busy=%b want 0", bz_n);
    end
    repeat (20) tick();
    checks++;
    if (q_n.size() !== 0 || q_m.size() !== 0) begin
      errors++;
      $display("FAIL glitch_push: got %0d words want 0", q_n.size());
    end
    send(1'b0, fr8(8'hA5, 1'b1), 10, 3);
    repeat (6) tick();
    checks++;
    if (q_n.size() !== 1 || q_n[0] !== 10'h0A5) begin
      errors++;
      $display("FAIL data_glitch: got %h want 0a5", q_n[0]);
    end
  endtask

  task automatic test_break();
    clear_q();
    send(1'b0, fr8(8'h55, 1'b0), 10, -1);
    repeat (30) tick();
    checks++;
    if (q_n.size() !== 1 || q_n[0] !== 10'h255) begin
      errors++;
      $display("FAIL break_ferr: got %h want 255", q_n[0]);
    end
    checks++;
    if (bz_n !== 1'b1) begin
      errors++;
      $display("FAIL break_hold: got busy=%b want 1", bz_n);
    end
    rx_a = 1'b1;
    repeat (20) tick();
    checks++;
    if (bz_n !== 1'b0 || q_n.size() !== 1) begin
      errors++;
      $display("FAIL break_exit: got busy=%b n=%0d want 0/1",
               bz_n, q_n.size());
    end
  endtask

  task automatic test_overrun();
    clear_q();
    ovc_n = 0;
    rdy_n = 1'b0;
    for (int b = 0; b < 4; b++) begin
      send(1'b0, fr8(8'(8'h10 + b), 1'b1), 10, -1);
    end
    repeat (6) tick();
    checks++;
    if (ovc_n !== 0) begin
      errors++;
      $display("FAIL ovr_early: got %0d want 0", ovc_n);
    end
    checks++;
    if (v_n !== 1'b1 || d_n !== 8'h10) begin
      errors++;
      $display("FAIL ovr_head: got v=%b d=%h want 1/10", v_n, d_n);
    end
    send(1'b0, fr8(8'h14, 1'b1), 10, -1);
    repeat (6) tick();
    checks++;
    if (ovc_n !== 1) begin
      errors++;
      $display("FAIL ovr_pulse: got %0d want 1", ovc_n);
    end
    rdy_n = 1'b1;
    repeat (8) tick();
    checks++;
    if (q_n.size() !== 4 || v_n !== 1'b0) begin
      errors++;
      $display("FAIL drain_count: got %0d want 4", q_n.size());
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q_n[k] !== 10'(8'h10 + k)) begin
        errors++;
        $display("FAIL drain_%0d: got %h want %h",
                 k, q_n[k], 10'(8'h10 + k));
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    rdy_n = 1'b0;
    send(1'b0, fr8(8'h77, 1'b1), 10, -1);
    repeat (6) tick();
    checks++;
    if (v_n !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_valid: got %b want 1", v_n);
    end
    send(1'b0, fr8(8'h00, 1'b1), 5, -1);
    rst = 1'b1;
    #1;
    checks++;
    if ({d_n, pe_n, fe_n, v_n, ov_n, bz_n} !== 14'h0) begin
      errors++;
      $display("FAIL rst_mid: got %h want 0",
               {d_n, pe_n, fe_n, v_n, ov_n, bz_n});
    end
    rx_a = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    rdy_n = 1'b1;
    repeat (3) tick();
    send(1'b0, fr8(8'h3C, 1'b1), 10, -1);
    repeat (6) tick();
    checks++;
    if (q_n.size() !== 1 || q_n[0] !== 10'h03C) begin
      errors++;
      $display("FAIL post_rst: got %h n=%0d want 03c",
               q_n[0], q_n.size());
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
